axi_lite_mem_slave: RTL and testbench

//  AXI4-Lite slave between the ARM host and the RISC-V core's distributed memory and control.

---
 rtl/axi_lite_mem_slave.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_axi_lite_mem_slave.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mem_slave.sv
// rtl/axi_lite_mem_slave.sv - AXI4-Lite slave bridging host accesses to core memory strobes and control
//
// Purpose:
//   Turns AXI4-Lite AR/AW/W/R/B handshakes into single-cycle MemRead/MemWrite
//   strobes on a word address. Owns the riscv_rst bit that keeps the RISC-V core
//   in reset while the host loads its program. Only one transaction is in flight.
//
// Address map (byte addresses, bits [1:0] ignored):
//   addr[13] = 0    memory, word address = addr[12:2]
//   0x2000          CTRL   bit0 = riscv_rst (R/W)
//   0x2004          CYCLES (RO) core-run cycle counter
//   other 0x2xxx    read 0 / write ignored, SLVERR
//
// Optional feature:
//   AXI_CYCLE_CNT_EN  when defined, CYCLES is a 32-bit counter that advances every
//                     cycle while riscv_rst == 0 and clears when riscv_rst falls.
//                     When undefined, CYCLES reads as 0 with OKAY.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN          clock, asynchronous active-low reset
//   S_AXI_AR*                          read address channel
//   S_AXI_AW*, S_AXI_W*                write address / write data channels
//   S_AXI_R*                           read data / response channel
//   S_AXI_B*                           write response channel
//   Address                            memory word address, valid with strobes
//   MemRead, Read_data                 read strobe, combinational memory data
//   MemWrite, Write_data               write strobe and data
//   riscv_rst                          registered core reset (1 = held)

module axi_lite_mem_slave #(
  parameter int   ADDR_W   = 14,
  parameter int   MEM_AW   = 11,
  parameter logic RST_INIT = 1'b1
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic [ADDR_W-1:0] S_AXI_ARADDR,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  input  logic [ADDR_W-1:0] S_AXI_AWADDR,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  output logic [MEM_AW-1:0] Address,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [31:0]       Read_data,
  output logic [31:0]       Write_data,
  output logic              riscv_rst
);

  localparam logic [1:0]        RESP_OKAY   = 2'b00;
  localparam logic [1:0]        RESP_SLVERR = 2'b10;
  localparam logic [MEM_AW-1:0] CTRL_WORD   = '0;
  localparam logic [MEM_AW-1:0] CYC_WORD    = MEM_AW'(1);
  localparam logic              RR_READ     = 1'b0;
  localparam logic              RR_WRITE    = 1'b1;
  localparam logic [31:0]       CONTENTION  = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    WR_COLLECT,
    RD_MEM,
    RD_RESP,
    WR_MEM,
    WR_RESP
  } state_t;

  typedef enum logic [1:0] {
    SEL_MEM,
    SEL_CTRL,
    SEL_CYC,
    SEL_BAD
  } sel_t;

  function automatic sel_t decode_sel(input logic region, input logic [MEM_AW-1:0] word);
    if (!region)                 return SEL_MEM;
    else if (word == CTRL_WORD)  return SEL_CTRL;
    else if (word == CYC_WORD)   return SEL_CYC;
    else                         return SEL_BAD;
  endfunction

  state_t state, state_nxt;

  // Early-arriving half of a write (AW or W) is parked here until its partner shows up.
  logic              aw_got, w_got;
  logic              aw_region_q;
  logic [MEM_AW-1:0] aw_word_q;
  logic [31:0]       w_data_q;
  logic [3:0]        w_strb_q;

  // Access decision is taken at the handshake so RD_MEM/WR_MEM need no address decode.
  sel_t              rd_sel_q;
  logic              wr_ctrl_q;

  logic [31:0]       rdata_q;
  logic [1:0]        rresp_q;
  logic [1:0]        bresp_q;
  logic [MEM_AW-1:0] address_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [31:0]       write_data_q;
  logic              riscv_rst_q;
  logic              rr_last_q;
  logic [31:0]       cycles_val;

  logic arready_c, awready_c, wready_c, rvalid_c, bvalid_c;
  logic ar_hs, aw_hs, w_hs;
  logic wr_start;

  logic              eff_aw_region;
  logic [MEM_AW-1:0] eff_aw_word;
  logic [31:0]       eff_wdata;
  logic [3:0]        eff_wstrb;
  sel_t              wr_sel;
  sel_t              ar_sel;

  // Byte-lane bits of the addresses carry no meaning for word-only access.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, S_AXI_ARADDR[1:0], S_AXI_AWADDR[1:0]};

  // Merge the parked half with the half arriving this cycle.
  assign eff_aw_region = aw_got ? aw_region_q : S_AXI_AWADDR[ADDR_W-1];
  assign eff_aw_word   = aw_got ? aw_word_q   : S_AXI_AWADDR[ADDR_W-2:2];
  assign eff_wdata     = w_got  ? w_data_q    : S_AXI_WDATA;
  assign eff_wstrb     = w_got  ? w_strb_q    : S_AXI_WSTRB;
  assign wr_sel        = decode_sel(eff_aw_region, eff_aw_word);
  assign ar_sel        = decode_sel(S_AXI_ARADDR[ADDR_W-1], S_AXI_ARADDR[ADDR_W-2:2]);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    arready_c = 1'b0;
    awready_c = 1'b0;
    wready_c  = 1'b0;
    rvalid_c  = 1'b0;
    bvalid_c  = 1'b0;
    ar_hs     = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    state_nxt = state;

    case (state)
      IDLE: begin
        // On a read/write collision the side served less recently wins; the
        // loser simply sees READY low and keeps its VALID asserted.
        arready_c = !((S_AXI_AWVALID || S_AXI_WVALID) && (rr_last_q == RR_READ));
        awready_c = !(S_AXI_ARVALID && (rr_last_q == RR_WRITE));
        wready_c  = !(S_AXI_ARVALID && (rr_last_q == RR_WRITE));
      end
      WR_COLLECT: begin
        awready_c = !aw_got;
        wready_c  = !w_got;
      end
      RD_RESP: rvalid_c = 1'b1;
      WR_RESP: bvalid_c = 1'b1;
      default: ;
    endcase

    // Nothing is accepted while reset is asserted.
    if (!S_AXI_ARESETN) begin
      arready_c = 1'b0;
      awready_c = 1'b0;
      wready_c  = 1'b0;
    end

    ar_hs = S_AXI_ARVALID && arready_c;
    aw_hs = S_AXI_AWVALID && awready_c;
    w_hs  = S_AXI_WVALID  && wready_c;

    case (state)
      IDLE: begin
        if (ar_hs)               state_nxt = RD_MEM;
        else if (aw_hs && w_hs)  state_nxt = WR_MEM;
        else if (aw_hs || w_hs)  state_nxt = WR_COLLECT;
      end
      WR_COLLECT: begin
        if ((aw_got || aw_hs) && (w_got || w_hs)) state_nxt = WR_MEM;
      end
      RD_MEM:  state_nxt = RD_RESP;
      RD_RESP: if (S_AXI_RREADY) state_nxt = IDLE;
      WR_MEM:  state_nxt = WR_RESP;
      WR_RESP: if (S_AXI_BREADY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_start = (state_nxt == WR_MEM) && (state != WR_MEM);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      aw_got       <= 1'b0;
      w_got        <= 1'b0;
      aw_region_q  <= 1'b0;
      aw_word_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      rd_sel_q     <= SEL_MEM;
      wr_ctrl_q    <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
      bresp_q      <= RESP_OKAY;
      address_q    <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      write_data_q <= '0;
      riscv_rst_q  <= RST_INIT;
      rr_last_q    <= RR_READ;
    end else begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;

      if (wr_start) begin
        aw_got       <= 1'b0;
        w_got        <= 1'b0;
        address_q    <= eff_aw_word;
        write_data_q <= eff_wdata;
        // Memory is writable only while the core is held and the word is fully strobed.
        mem_write_q  <= (wr_sel == SEL_MEM) && riscv_rst_q && (eff_wstrb == 4'hF);
        wr_ctrl_q    <= (wr_sel == SEL_CTRL) && eff_wstrb[0];
        case (wr_sel)
          SEL_MEM:  bresp_q <= (riscv_rst_q && (eff_wstrb == 4'hF)) ? RESP_OKAY : RESP_SLVERR;
          SEL_CTRL: bresp_q <= RESP_OKAY;
          SEL_CYC:  bresp_q <= RESP_OKAY;
          default:  bresp_q <= RESP_SLVERR;
        endcase
      end else begin
        if (aw_hs) begin
          aw_got      <= 1'b1;
          aw_region_q <= S_AXI_AWADDR[ADDR_W-1];
          aw_word_q   <= S_AXI_AWADDR[ADDR_W-2:2];
        end
        if (w_hs) begin
          w_got    <= 1'b1;
          w_data_q <= S_AXI_WDATA;
          w_strb_q <= S_AXI_WSTRB;
        end
      end

      if (ar_hs) begin
        rd_sel_q   <= ar_sel;
        address_q  <= S_AXI_ARADDR[ADDR_W-2:2];
        mem_read_q <= (ar_sel == SEL_MEM);
      end

      case (state)
        RD_MEM: begin
          case (rd_sel_q)
            SEL_MEM: begin
              rdata_q <= Read_data;
              // All-ones from the arbiter means the running core won the memory port.
              rresp_q <= ((Read_data == CONTENTION) && !riscv_rst_q) ? RESP_SLVERR : RESP_OKAY;
            end
            SEL_CTRL: begin
              rdata_q <= {31'd0, riscv_rst_q};
              rresp_q <= RESP_OKAY;
            end
            SEL_CYC: begin
              rdata_q <= cycles_val;
              rresp_q <= RESP_OKAY;
            end
            default: begin
              rdata_q <= '0;
              rresp_q <= RESP_SLVERR;
            end
          endcase
        end
        RD_RESP: if (S_AXI_RREADY) rr_last_q <= RR_READ;
        WR_MEM:  if (wr_ctrl_q) riscv_rst_q <= write_data_q[0];
        WR_RESP: if (S_AXI_BREADY) rr_last_q <= RR_WRITE;
        default: ;
      endcase
    end
  end

`ifdef AXI_CYCLE_CNT_EN
  logic [31:0] cyc_cnt_q;
  logic        rst_fall;

  // The counter restarts from zero each time the core is released.
  assign rst_fall = (state == WR_MEM) && wr_ctrl_q && riscv_rst_q && !write_data_q[0];

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)    cyc_cnt_q <= '0;
    else if (rst_fall)     cyc_cnt_q <= '0;
    else if (!riscv_rst_q) cyc_cnt_q <= cyc_cnt_q + 32'd1;
  end

  assign cycles_val = cyc_cnt_q;
`else
  assign cycles_val = '0;
`endif

  assign S_AXI_ARREADY = arready_c;
  assign S_AXI_AWREADY = awready_c;
  assign S_AXI_WREADY  = wready_c;
  assign S_AXI_RVALID  = rvalid_c;
  assign S_AXI_BVALID  = bvalid_c;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_BRESP   = bresp_q;
  assign Address       = address_q;
  assign MemRead       = mem_read_q;
  assign MemWrite      = mem_write_q;
  assign Write_data    = write_data_q;
  assign riscv_rst     = riscv_rst_q;

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// tb/tb_axi_lite_mem_slave.sv - directed self-checking bench for axi_lite_mem_slave

module tb_axi_lite_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [13:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [10:0] address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] read_data = '0;
  logic [31:0] write_data;
  logic        riscv_rst;

  int checks = 0;
  int errors = 0;
  int mw_pulses = 0;
  int mw_base;
  logic [31:0] exp_cycles;

  axi_lite_mem_slave dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .Address       (address),
    .MemRead       (mem_read),
    .MemWrite      (mem_write),
    .Read_data     (read_data),
    .Write_data    (write_data),
    .riscv_rst     (riscv_rst)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_write) mw_pulses++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ar();
    int n = 0;
    @(negedge clk);
    while (!arready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rd_accept", 32'(arready), 32'd1);
  endtask

  task automatic wait_aw_w();
    int n = 0;
    @(negedge clk);
    while (!(awready && wready) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("wr_accept", 32'(awready && wready), 32'd1);
  endtask

  // Called just after a rising edge with the slave idle; returns the same way.
  task automatic do_write(input logic [13:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic exp_mw, input logic [1:0] exp_bresp);
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    wait_aw_w();
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("memwrite", 32'(mem_write), 32'(exp_mw));
    if (exp_mw) begin
      check("wr_address", 32'(address), 32'(addr[12:2]));
      check("wr_data", write_data, data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("bvalid", 32'(bvalid), 32'd1);
    check("bresp", 32'(bresp), 32'(exp_bresp));
    check("memwrite_off", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [13:0] addr, input logic [31:0] mem_val, input logic exp_mr,
                         input logic [31:0] exp_rdata, input logic [1:0] exp_rresp, input int hold);
    araddr = addr; read_data = mem_val; rready = (hold == 0); arvalid = 1'b1;
    wait_ar();
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("memread", 32'(mem_read), 32'(exp_mr));
    if (exp_mr) check("rd_address", 32'(address), 32'(addr[12:2]));
    @(posedge clk); #1;
    @(negedge clk);
    check("rvalid", 32'(rvalid), 32'd1);
    check("rdata", rdata, exp_rdata);
    check("rresp", 32'(rresp), 32'(exp_rresp));
    check("memread_off", 32'(mem_read), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("rvalid_hold", 32'(rvalid), 32'd1);
      check("rdata_hold", rdata, exp_rdata);
    end
    rready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_memread", 32'(mem_read), 32'd0);
    check("rst_memwrite", 32'(mem_write), 32'd0);
    check("rst_riscv_rst", 32'(riscv_rst), 32'd1);
    check("rst_address", 32'(address), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_write_data", write_data, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Memory write and readback with RREADY stalled
    do_write(14'h0010, 32'hDEADBEEF, 4'hF, 1'b1, 2'b00);
    do_read(14'h0010, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 2'b00, 5);
    do_read(14'h0000, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 2'b00, 0);

    // W arrives three cycles ahead of AW
    mw_base = mw_pulses;
    wdata = 32'hA5A5_0001; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    check("w_first_wready", 32'(wready), 32'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("collect_arready", 32'(arready), 32'd0);
      check("collect_wready", 32'(wready), 32'd0);
      check("collect_memwrite", 32'(mem_write), 32'd0);
      @(posedge clk); #1;
    end
    awaddr = 14'h0108; awvalid = 1'b1;
    @(negedge clk);
    check("late_awready", 32'(awready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    check("collect_mw", 32'(mem_write), 32'd1);
    check("collect_addr", 32'(address), 32'h042);
    check("collect_data", write_data, 32'hA5A5_0001);
    @(posedge clk); #1;
    @(negedge clk);
    check("collect_bvalid", 32'(bvalid), 32'd1);
    check("collect_bresp", 32'(bresp), 32'd0);
    @(posedge clk); #1;
    check("collect_pulses", 32'(mw_pulses - mw_base), 32'd1);

    // Partial strobe on memory is refused
    do_write(14'h0024, 32'h0BADF00D, 4'h3, 1'b0, 2'b10);

    // CTRL readback, then release the core
    do_read(14'h2000, 32'h0, 1'b0, 32'h1, 2'b00, 0);
    do_write(14'h2000, 32'h0, 4'h1, 1'b0, 2'b00);
    check("released", 32'(riscv_rst), 32'd0);

    // 98 idle edges + AR handshake edge + capture edge puts CYCLES at 100
    repeat (98) @(posedge clk);
    #1;
`ifdef AXI_CYCLE_CNT_EN
    exp_cycles = 32'd100;
`else
    exp_cycles = 32'd0;
`endif
    do_read(14'h2004, 32'h0, 1'b0, exp_cycles, 2'b00, 0);

    // Core running: memory writes refused, contention flagged
    do_write(14'h0040, 32'h11111111, 4'hF, 1'b0, 2'b10);
    do_read(14'h0040, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 2'b10, 0);
    do_read(14'h0044, 32'h00000007, 1'b1, 32'h00000007, 2'b00, 0);
    do_read(14'h2008, 32'h00001234, 1'b0, 32'h0, 2'b10, 0);
    do_write(14'h2010, 32'h1, 4'hF, 1'b0, 2'b10);
    do_read(14'h2003, 32'h0, 1'b0, 32'h0, 2'b00, 0);
    check("still_released", 32'(riscv_rst), 32'd0);

    // Asynchronous reset while RVALID is up
    araddr = 14'h0010; read_data = 32'h55AA55AA; rready = 1'b0; arvalid = 1'b1;
    wait_ar();
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_rvalid", 32'(rvalid), 32'd1);
    check("pre_rst_rdata", rdata, 32'h55AA55AA);
    #2 rst_n = 1'b0;
    #1;
    check("async_rvalid", 32'(rvalid), 32'd0);
    check("async_riscv_rst", 32'(riscv_rst), 32'd1);
    check("async_rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; rready = 1'b1;
    @(posedge clk); #1;

    // Collision after reset: write wins first
    araddr = 14'h0010; arvalid = 1'b1; read_data = 32'hCAFEF00D;
    awaddr = 14'h0020; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    check("arb1_arready", 32'(arready), 32'd0);
    check("arb1_awready", 32'(awready), 32'd1);
    check("arb1_wready", 32'(wready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("arb1_memwrite", 32'(mem_write), 32'd1);
    check("arb1_wr_addr", 32'(address), 32'h008);
    check("arb1_ar_held", 32'(arready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("arb1_bvalid", 32'(bvalid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("arb1_ar_now", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("arb1_memread", 32'(mem_read), 32'd1);
    check("arb1_rd_addr", 32'(address), 32'h004);
    @(posedge clk); #1;
    @(negedge clk);
    check("arb1_rvalid", 32'(rvalid), 32'd1);
    check("arb1_rdata", rdata, 32'hCAFEF00D);
    @(posedge clk); #1;

    // After a write, a collision goes to the read
    do_write(14'h0030, 32'h0000BEEF, 4'hF, 1'b1, 2'b00);
    araddr = 14'h0030; arvalid = 1'b1; read_data = 32'h0000BEEF;
    awaddr = 14'h0034; wdata = 32'h00C0FFEE; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    check("arb2_arready", 32'(arready), 32'd1);
    check("arb2_awready", 32'(awready), 32'd0);
    check("arb2_wready", 32'(wready), 32'd0);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("arb2_memread", 32'(mem_read), 32'd1);
    check("arb2_aw_held", 32'(awready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("arb2_rvalid", 32'(rvalid), 32'd1);
    check("arb2_rdata", rdata, 32'h0000BEEF);
    @(posedge clk); #1;
    @(negedge clk);
    check("arb2_aw_now", 32'(awready && wready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("arb2_memwrite", 32'(mem_write), 32'd1);
    check("arb2_wr_addr", 32'(address), 32'h00D);
    @(posedge clk); #1;
    @(negedge clk);
    check("arb2_bvalid", 32'(bvalid), 32'd1);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
